// File: rtl/mem_recall_ctrl_pkg.sv
// Shared types, default button codes and width helpers for the memory-command
// controller. No ports; imported by the interface, the timer and the controller.
package mem_ctrl_pkg;

  localparam int unsigned DEF_BTN_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [DEF_BTN_W-1:0] RECALL_CODE = 5'b10010;
  localparam logic [DEF_BTN_W-1:0] STORE_CODE  = 5'b10001;
  localparam logic [DEF_BTN_W-1:0] CLEAR_CODE  = 5'b10100;

  // Width of the slot index; at least one bit even for a single slot.
  function automatic int unsigned slot_w(input int unsigned slots);
    return (slots <= 1) ? 1 : $clog2(slots);
  endfunction

endpackage

// File: rtl/mem_recall_ctrl_if.sv
// Button-pulse / memory-command bundle between the input manager (master)
// and the memory-command controller (slave).
//   buttonPulse : one-cycle pulse code, 0 when idle
//   ld_m/st_m/clr_m : one-cycle load/store/clear strobes
//   slot        : selected memory slot
//   pending     : recall selection in progress
interface mem_recall_ctrl_if #(
  parameter int unsigned BTN_W = 5,
  parameter int unsigned SW    = 2
);
  logic [BTN_W-1:0] buttonPulse;
  logic             ld_m;
  logic             st_m;
  logic             clr_m;
  logic [SW-1:0]    slot;
  logic             pending;

  modport master (
    output buttonPulse,
    input  ld_m, st_m, clr_m, slot, pending
  );

  modport slave (
    input  buttonPulse,
    output ld_m, st_m, clr_m, slot, pending
  );
endinterface

// File: rtl/mem_recall_ctrl_timer.sv
// Reloadable down-counter measuring the multi-press window.
//   clk, reset : clock and synchronous active-high reset
//   load       : reload to WINDOW-1
//   expired    : counter has reached zero
module press_window_timer #(
  parameter int unsigned WINDOW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int unsigned TW = $clog2(WINDOW + 1);

  logic [TW-1:0] timer;

  // Saturates at zero; only consulted by the controller while collecting presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (load) begin
      timer <= TW'(WINDOW - 1);
    end else if (timer != '0) begin
      timer <= timer - TW'(1);
    end
  end

  assign expired = (timer == '0);

endmodule

// File: rtl/mem_recall_ctrl.sv
// Memory-command controller: decodes button pulses into registered load,
// store and clear strobes; repeated recall presses within a window select
// one of SLOTS memory slots.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of mem_recall_ctrl_if (buttonPulse in; ld_m,
//                st_m, clr_m, slot, pending out, all registered)
module mem_recall_ctrl #(
  parameter int unsigned          BTN_W       = 5,
  parameter int unsigned          SLOTS       = 4,
  parameter int unsigned          WINDOW      = 16,
  parameter logic [BTN_W-1:0]     RECALL_CODE = BTN_W'(mem_ctrl_pkg::RECALL_CODE),
  parameter logic [BTN_W-1:0]     STORE_CODE  = BTN_W'(mem_ctrl_pkg::STORE_CODE),
  parameter logic [BTN_W-1:0]     CLEAR_CODE  = BTN_W'(mem_ctrl_pkg::CLEAR_CODE)
) (
  input logic              clk,
  input logic              reset,
  mem_recall_ctrl_if.slave bus
);
  import mem_ctrl_pkg::*;

  localparam int unsigned SW = slot_w(SLOTS);

  // Elaboration-time parameter sanity.
  if (RECALL_CODE == STORE_CODE || RECALL_CODE == CLEAR_CODE ||
      STORE_CODE == CLEAR_CODE) begin : g_code_clash
    $error("mem_recall_ctrl: button codes must be pairwise distinct");
  end
  if (SLOTS < 1 || WINDOW < 1) begin : g_param_range
    $error("mem_recall_ctrl: SLOTS and WINDOW must be at least 1");
  end

  state_t        state;
  logic [SW-1:0] presses;
  logic [SW-1:0] slot_q;
  logic          ld_q, st_q, clr_q, pending_q;
  logic          is_recall, is_store, is_clear;
  logic          timer_expired;

  assign is_recall = (bus.buttonPulse == RECALL_CODE);
  assign is_store  = (bus.buttonPulse == STORE_CODE);
  assign is_clear  = (bus.buttonPulse == CLEAR_CODE);

  // Every recall press (re)opens the window.
  press_window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (is_recall),
    .expired (timer_expired)
  );

  // Command FSM with registered strobes; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      presses   <= '0;
      slot_q    <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      clr_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      ld_q  <= 1'b0;
      st_q  <= 1'b0;
      clr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_recall) begin
            state     <= COUNT;
            presses   <= '0;
            pending_q <= 1'b1;
          end else if (is_store) begin
            st_q <= 1'b1;
          end else if (is_clear) begin
            clr_q  <= 1'b1;
            slot_q <= '0;
          end
        end
        COUNT: begin
          // A recall on the expiry cycle extends the window instead of firing.
          if (is_recall) begin
            presses <= (presses == SW'(SLOTS - 1)) ? '0 : presses + SW'(1);
          end else if (is_clear) begin
            clr_q     <= 1'b1;
            slot_q    <= '0;
            state     <= IDLE;
            pending_q <= 1'b0;
          end else if (timer_expired) begin
            ld_q      <= 1'b1;
            slot_q    <= presses;
            state     <= IDLE;
            pending_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_m    = ld_q;
  assign bus.st_m    = st_q;
  assign bus.clr_m   = clr_q;
  assign bus.slot    = slot_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_mem_recall_ctrl.sv
// Scoreboard bench: dut_a (WINDOW=4, SLOTS=4) and dut_b (WINDOW=1, SLOTS=1).
// Stimulus pushes expected strobes {edge, kind, slot}; a negedge monitor pops
// and compares whenever a strobe appears, and flags strobes that never came.
module tb_mem_recall_ctrl;
  import mem_ctrl_pkg::*;

  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_CLR = 2;

  typedef struct {
    int cyc;
    int kind;
    int slot;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   edge_n = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  q[2][$];

  mem_recall_ctrl_if #(.BTN_W(5), .SW(2)) bus_a ();
  mem_recall_ctrl_if #(.BTN_W(5), .SW(1)) bus_b ();

  mem_recall_ctrl #(.BTN_W(5), .SLOTS(4), .WINDOW(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  mem_recall_ctrl #(.BTN_W(5), .SLOTS(1), .WINDOW(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  // Present code so that it is sampled at edge e; returns just after edge e.
  task automatic press_at(input int k, input int e, input logic [4:0] code);
    wait_until(e - 1);
    if (k == 0) bus_a.buttonPulse = code;
    else        bus_b.buttonPulse = code;
    @(negedge clk);
    bus_a.buttonPulse = '0;
    bus_b.buttonPulse = '0;
  endtask

  task automatic expect_ev(input int k, input int cyc, input int kind, input int slot);
    q[k].push_back('{cyc, kind, slot});
  endtask

  // Monitor: compare each presented strobe with the scoreboard head.
  logic  m_ld, m_st, m_clr;
  int    m_sl, m_kind;
  ev_t   m_e;
  always @(negedge clk) begin
    if (edge_n > 0) begin
      for (int k = 0; k < 2; k++) begin
        m_ld  = (k == 0) ? bus_a.ld_m  : bus_b.ld_m;
        m_st  = (k == 0) ? bus_a.st_m  : bus_b.st_m;
        m_clr = (k == 0) ? bus_a.clr_m : bus_b.clr_m;
        m_sl  = (k == 0) ? int'(bus_a.slot) : int'(bus_b.slot);
        if (q[k].size() > 0 && q[k][0].cyc < edge_n) begin
          m_e = q[k].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL dut%0d missing strobe: kind %0d slot %0d expected at edge %0d, none by edge %0d",
                   k, m_e.kind, m_e.slot, m_e.cyc, edge_n);
        end
        if (m_ld || m_st || m_clr) begin
          vectors++;
          m_kind = m_ld ? K_LD : (m_st ? K_ST : K_CLR);
          if (int'(m_ld) + int'(m_st) + int'(m_clr) > 1) begin
            miscompares++;
            $display("FAIL dut%0d strobe exclusivity at edge %0d: ld=%0b st=%0b clr=%0b, required at most one",
                     k, edge_n, m_ld, m_st, m_clr);
          end else if (q[k].size() == 0) begin
            miscompares++;
            $display("FAIL dut%0d unexpected strobe kind %0d slot %0d at edge %0d, required none",
                     k, m_kind, m_sl, edge_n);
          end else begin
            m_e = q[k].pop_front();
            if (m_e.cyc != edge_n || m_e.kind != m_kind || m_e.slot != m_sl) begin
              miscompares++;
              $display("FAIL dut%0d strobe: got kind %0d slot %0d at edge %0d, expected kind %0d slot %0d at edge %0d",
                       k, m_kind, m_sl, edge_n, m_e.kind, m_e.slot, m_e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.buttonPulse = '0;
    bus_b.buttonPulse = '0;
    reset = 1'b1;
    wait_until(2);
    chk("reset ld_m",    int'(bus_a.ld_m), 0);
    chk("reset st_m",    int'(bus_a.st_m), 0);
    chk("reset clr_m",   int'(bus_a.clr_m), 0);
    chk("reset pending", int'(bus_a.pending), 0);
    chk("reset slot",    int'(bus_a.slot), 0);
    chk("reset b pending", int'(bus_b.pending), 0);
    reset = 1'b0;

    // Single recall at edge 10: window of 4 -> load at 14, slot 0.
    expect_ev(0, 14, K_LD, 0);
    wait_until(9);
    chk("pending before recall", int'(bus_a.pending), 0);
    press_at(0, 10, RECALL_CODE);
    chk("pending at first press", int'(bus_a.pending), 1);
    wait_until(13);
    chk("pending before expiry", int'(bus_a.pending), 1);
    wait_until(14);
    chk("pending drops with ld_m", int'(bus_a.pending), 0);

    // Three recalls 20,22,25 -> load at 29, slot 2.
    expect_ev(0, 29, K_LD, 2);
    press_at(0, 20, RECALL_CODE);
    press_at(0, 22, RECALL_CODE);
    press_at(0, 25, RECALL_CODE);

    // Fourth press lands on the expiry cycle (49): no fire, load at 53 slot 3.
    expect_ev(0, 53, K_LD, 3);
    press_at(0, 40, RECALL_CODE);
    press_at(0, 42, RECALL_CODE);
    press_at(0, 45, RECALL_CODE);
    press_at(0, 49, RECALL_CODE);
    chk("pending after expiry-cycle press", int'(bus_a.pending), 1);

    // Store in IDLE keeps the last slot (3).
    expect_ev(0, 56, K_ST, 3);
    press_at(0, 56, STORE_CODE);

    // Five back-to-back recalls wrap to slot 0; then store shows slot 0.
    expect_ev(0, 68, K_LD, 0);
    for (int i = 0; i < 5; i++) press_at(0, 60 + i, RECALL_CODE);
    expect_ev(0, 70, K_ST, 0);
    press_at(0, 70, STORE_CODE);

    // Load slot 1, then recall + clear two cycles later aborts with slot 0.
    expect_ev(0, 79, K_LD, 1);
    press_at(0, 74, RECALL_CODE);
    press_at(0, 75, RECALL_CODE);
    expect_ev(0, 82, K_CLR, 0);
    press_at(0, 80, RECALL_CODE);
    press_at(0, 82, CLEAR_CODE);
    chk("pending after clear abort", int'(bus_a.pending), 0);

    // Store during COUNT is ignored and does not move the fire time.
    expect_ev(0, 94, K_LD, 0);
    press_at(0, 90, RECALL_CODE);
    press_at(0, 92, STORE_CODE);
    chk("pending after store in COUNT", int'(bus_a.pending), 1);

    // Load slot 1, then reset mid-COUNT: everything zero, no later load.
    expect_ev(0, 101, K_LD, 1);
    press_at(0, 96, RECALL_CODE);
    press_at(0, 97, RECALL_CODE);
    press_at(0, 103, RECALL_CODE);
    press_at(0, 104, RECALL_CODE);
    wait_until(105);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-count reset ld_m",    int'(bus_a.ld_m), 0);
    chk("mid-count reset st_m",    int'(bus_a.st_m), 0);
    chk("mid-count reset clr_m",   int'(bus_a.clr_m), 0);
    chk("mid-count reset pending", int'(bus_a.pending), 0);
    chk("mid-count reset slot",    int'(bus_a.slot), 0);
    reset = 1'b0;

    // Non-matching patterns are ignored; clear in IDLE strobes.
    press_at(0, 112, 5'b00010);
    press_at(0, 113, 5'b11111);
    chk("pending after junk codes", int'(bus_a.pending), 0);
    expect_ev(0, 115, K_CLR, 0);
    press_at(0, 115, CLEAR_CODE);

    wait_until(125);
    chk("dut_a scoreboard drained", q[0].size(), 0);

    // WINDOW=1, SLOTS=1: load the edge after the press.
    expect_ev(1, 141, K_LD, 0);
    press_at(1, 140, RECALL_CODE);
    chk("b pending at press", int'(bus_b.pending), 1);
    wait_until(141);
    chk("b pending after load", int'(bus_b.pending), 0);
    expect_ev(1, 152, K_LD, 0);
    press_at(1, 150, RECALL_CODE);
    press_at(1, 151, RECALL_CODE);
    wait_until(152);
    chk("b pending after wrap load", int'(bus_b.pending), 0);

    wait_until(160);
    chk("dut_b scoreboard drained", q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
